// File: rtl/frodo_mem_pkg.sv
// Shared defaults and requester indices for the FrodoKEM RAM port arbiter.
package frodo_mem_pkg;
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_NREQ       = 3;
    localparam int DEF_MAX_BURST  = 4;

    localparam int REQ_CTRL = 0;
    localparam int REQ_MACS = 1;
    localparam int REQ_ENC  = 2;

    function automatic int next_ptr(input int k, input int n);
        return (k + 1 >= n) ? 0 : k + 1;
    endfunction
endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above start, wrapping to 0.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   start,
    output logic [NREQ-1:0] gnt
);

    logic found;
    int   idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(start) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single RAM port shared by several requesters: sticky owner with bounded
// burst, round-robin hand-over, one-cycle read return to the granted requester.
module mem_port_arbiter
    import frodo_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NREQ       = DEF_NREQ,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            req_we,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       ram_we,
    output logic [ADDR_WIDTH-1:0]      ram_addr,
    output logic [DATA_WIDTH-1:0]      ram_din,
    input  logic [DATA_WIDTH-1:0]      ram_dout
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAX_BURST) + 1;

    logic [IW-1:0]   owner;
    logic            owner_vld;
    logic [BW-1:0]   burst_cnt;
    logic [IW-1:0]   rr_ptr;
    logic [NREQ-1:0] rd_pend;

    logic [NREQ-1:0] rot_gnt;
    logic [NREQ-1:0] owner_mask;
    logic [NREQ-1:0] gnt_int;
    logic [IW-1:0]   gnt_idx;
    logic            keep;
    logic            any_gnt;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
        .req   (req),
        .start (rr_ptr),
        .gnt   (rot_gnt)
    );

    // Owner keeps the port until its burst is used up, unless nobody else wants it.
    always_comb begin
        owner_mask        = '0;
        owner_mask[owner] = 1'b1;
        keep    = owner_vld && req[owner] &&
                  ((burst_cnt < BW'(MAX_BURST - 1)) || ((req & ~owner_mask) == '0));
        gnt_int = '0;
        if (!rstn) gnt_int = keep ? owner_mask : rot_gnt;
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_int[i]) gnt_idx = IW'(i);
        end
        any_gnt = |gnt_int;
    end

    assign gnt      = gnt_int;
    assign ram_we   = any_gnt & req_we[gnt_idx];
    assign ram_addr = any_gnt ? req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign ram_din  = any_gnt ? req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign rvalid   = rd_pend;
    assign rdata    = ram_dout;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            owner     <= '0;
            owner_vld <= 1'b0;
            burst_cnt <= '0;
            rr_ptr    <= '0;
            rd_pend   <= '0;
        end else if (any_gnt) begin
            owner     <= gnt_idx;
            owner_vld <= 1'b1;
            if (owner_vld && (gnt_idx == owner))
                burst_cnt <= (burst_cnt == '1) ? burst_cnt : burst_cnt + 1'b1;
            else
                burst_cnt <= '0;
            rr_ptr    <= IW'(next_ptr(int'(gnt_idx), NREQ));
            rd_pend   <= req_we[gnt_idx] ? '0 : gnt_int;
        end else begin
            owner_vld <= 1'b0;
            burst_cnt <= '0;
            rd_pend   <= '0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: reference arbitration model plus RAM model,
// read returns checked by an independent monitor.
module tb_mem_port_arbiter;
    import frodo_mem_pkg::*;

    localparam int AW = DEF_ADDR_WIDTH;
    localparam int DW = DEF_DATA_WIDTH;
    localparam int N  = DEF_NREQ;
    localparam int MB = DEF_MAX_BURST;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_din;
    logic [DW-1:0]   ram_dout = '0;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREQ(N), .MAX_BURST(MB)) dut (
        .clk(clk), .rstn(rstn), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Synchronous single-port RAM behind the arbiter.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_din;
        ram_dout <= ram[ram_addr];
    end

    // Reference model: current owner, length of its current run, rotate pointer.
    int            m_owner = -1;
    int            m_run = 0;
    int            m_ptr = 0;
    logic [DW-1:0] ref_mem [int];

    typedef struct {
        int            due;
        logic [N-1:0]  oh;
        logic [DW-1:0] data;
    } rd_exp_t;
    rd_exp_t sbq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycle);
        end
    endtask

    function automatic logic [DW-1:0] mem_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    function automatic int model_pick(input logic [N-1:0] r);
        int others = 0;
        if (m_owner >= 0 && r[m_owner]) begin
            for (int i = 0; i < N; i++) if (i != m_owner && r[i]) others++;
            if (m_run < MB || others == 0) return m_owner;
        end
        for (int i = 0; i < N; i++) begin
            int j;
            j = (m_ptr + i) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic do_cycle(output logic [N-1:0] g_obs, output int k);
        logic [N-1:0] eg;
        int a;
        rd_exp_t e;
        k = -1;
        @(negedge clk);
        g_obs = gnt;
        if (rstn) begin
            chk("rst_gnt", gnt, 0);
            chk("rst_ram_we", ram_we, 0);
        end else begin
            k = model_pick(req);
            eg = '0;
            if (k >= 0) eg[k] = 1'b1;
            chk("gnt", gnt, eg);
            if (k >= 0) begin
                a = int'(req_addr[k*AW +: AW]);
                chk("ram_we", ram_we, req_we[k]);
                chk("ram_addr", ram_addr, a);
                chk("ram_din", ram_din, req_wdata[k*DW +: DW]);
                if (req_we[k]) ref_mem[a] = req_wdata[k*DW +: DW];
                else begin
                    e.due = cycle + 1; e.oh = eg; e.data = mem_rd(a);
                    sbq.push_back(e);
                end
                m_run   = (k == m_owner) ? m_run + 1 : 1;
                m_owner = k;
                m_ptr   = (k + 1) % N;
            end else begin
                chk("idle_ram_we", ram_we, 0);
                chk("idle_ram_addr", ram_addr, 0);
                chk("idle_ram_din", ram_din, 0);
                m_owner = -1;
                m_run   = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        logic [N-1:0] g;
        int k;
        rstn = 1'b1;
        sbq.delete();
        m_owner = -1; m_run = 0; m_ptr = 0;
        repeat (n) do_cycle(g, k);
        rstn = 1'b0;
    endtask

    task automatic set_req(input int i, input logic on, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i] = on;
        req_we[i] = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    // Monitor: each cycle either the oldest expected read is due, or rvalid must be quiet.
    always @(negedge clk) begin
        rd_exp_t e;
        if (sbq.size() > 0 && sbq[0].due == cycle) begin
            e = sbq.pop_front();
            chk("rvalid", rvalid, e.oh);
            chk("rdata", rdata, e.data);
        end else begin
            chk("rvalid_idle", rvalid, 0);
        end
    end

    logic [N-1:0] seq_burst [6];
    logic [N-1:0] g;
    int           k;
    logic [N-1:0] pend;

    initial begin
        seq_burst = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010};
        #2;
        apply_reset(3);

        // All three read: owner 0 gets MAX_BURST grants, then hand-over.
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(16 * i + 3), '0);
        for (int c = 0; c < 6; c++) begin
            do_cycle(g, k);
            chk("burst_seq", g, seq_burst[c]);
        end

        // Idle gap, then rotation resumes from the held pointer.
        req = '0;
        for (int c = 0; c < 3; c++) begin
            do_cycle(g, k);
            chk("idle_gap_gnt", g, 0);
        end
        set_req(1, 1'b1, 1'b0, 12'h007, '0);
        set_req(2, 1'b1, 1'b0, 12'h008, '0);
        do_cycle(g, k);
        chk("held_ptr_gnt", g, 3'b100);
        req = '0;
        do_cycle(g, k);

        // Lone writer granted every cycle, then reads its data back.
        set_req(1, 1'b1, 1'b1, 12'h005, 64'hDEAD_BEEF_0000_0001);
        for (int c = 0; c < 10; c++) begin
            do_cycle(g, k);
            chk("lone_wr_gnt", g, 3'b010);
        end
        set_req(1, 1'b1, 1'b0, 12'h005, '0);
        do_cycle(g, k);
        chk("rd5_gnt", g, 3'b010);
        chk("rd5_rvalid", rvalid, 3'b010);
        chk("rd5_rdata", rdata, 64'hDEAD_BEEF_0000_0001);
        req = '0;
        do_cycle(g, k);

        // Owner drops mid-burst: waiting requester takes over in the same cycle.
        set_req(0, 1'b1, 1'b0, 12'h001, '0);
        repeat (3) do_cycle(g, k);
        set_req(0, 1'b0, 1'b0, 12'h001, '0);
        set_req(2, 1'b1, 1'b0, 12'h002, '0);
        do_cycle(g, k);
        chk("drop_gnt", g, 3'b100);
        set_req(0, 1'b1, 1'b0, 12'h001, '0);
        do_cycle(g, k);
        chk("new_owner_keep", g, 3'b100);
        req = '0;
        do_cycle(g, k);

        // Back-to-back reads from different requesters.
        set_req(0, 1'b1, 1'b1, 12'h010, 64'h1111_2222_3333_0010);
        do_cycle(g, k);
        set_req(0, 1'b1, 1'b1, 12'h020, 64'h4444_5555_6666_0020);
        do_cycle(g, k);
        set_req(0, 1'b1, 1'b0, 12'h010, '0);
        do_cycle(g, k);
        chk("b2b_rvalid0", rvalid, 3'b001);
        chk("b2b_rdata0", rdata, 64'h1111_2222_3333_0010);
        set_req(0, 1'b0, 1'b0, 12'h010, '0);
        set_req(2, 1'b1, 1'b0, 12'h020, '0);
        do_cycle(g, k);
        chk("b2b_rvalid2", rvalid, 3'b100);
        chk("b2b_rdata2", rdata, 64'h4444_5555_6666_0020);
        req = '0;
        do_cycle(g, k);

        // Reset right after a granted read discards the return.
        set_req(0, 1'b1, 1'b0, 12'h010, '0);
        do_cycle(g, k);
        req = '0;
        apply_reset(1);
        chk("rst_rvalid", rvalid, 0);
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(i), '0);
        do_cycle(g, k);
        chk("post_rst_gnt", g, 3'b001);
        req = '0;
        do_cycle(g, k);

        // Randomised traffic; each requester holds its request until granted.
        pend = '0;
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 40) begin
                    pend[i] = 1'b1;
                    set_req(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                            {$urandom, $urandom});
                end else if (!pend[i]) begin
                    set_req(i, 1'b0, 1'($urandom_range(0, 1)), AW'($urandom), {$urandom, $urandom});
                end
            end
            if ($urandom_range(0, 99) < 2) begin
                apply_reset(1);
            end else begin
                do_cycle(g, k);
                if (k >= 0) pend[k] = 1'b0;
            end
        end
        req = '0;
        repeat (3) do_cycle(g, k);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
